chord_sequencer: RTL
====================

# chord_sequencer

Sequences the four chord voices that feed the audio synthesis voices in music mode. It takes the game's one or two current frequency ids, derives a base note and a major/minor flavour, and steps a fixed I–IV–V–I progression. Each chord is separated by a silence, and timing is paced by an external PWM-period tick. It outputs four voice frequency ids plus a one-cycle change strobe, ready to drive the per-voice wave generators and the mixer.

## Interface
- NOTE_LENGTH, default 20: a chord lasts 2^NOTE_LENGTH ticks.
- SIL_LENGTH, default 17: a silence lasts 2^SIL_LENGTH ticks.
- clock in 1: system clock (65 MHz).
- reset in 1: asynchronous, active-high.
- tick in 1: one-cycle strobe, once per PWM period; advances the timers.
- music in 1: 1 enables sequencing; 0 forces IDLE.
- freq_id1 in 5: primary game frequency id; 31 means none.
- freq_id2 in 5: secondary game frequency id; 31 means none.
- new_f in 1: one-cycle strobe; the frequency ids changed.
- voice0..voice3 out 5 each: voice frequency ids; 31 means rest.
- new_f_notes out 1: one-cycle strobe, high in the cycle the voices take new values.
- note out 1: high in NOTE.
- sil out 1: high in SIL.
- step out 2: progression index; 0=I, 1=IV, 2=V, 3=I.

## Operation
- States:
  - IDLE: voices=31, note=0, sil=0.
  - NOTE: voices=chord, note=1.
  - SIL: voices=31, sil=1.
- Base note latched on an accepted new_f:
  - lower = min(freq_id1, freq_id2) if freq_id2≠31, else freq_id1.
  - base = lower if lower<13, else lower−12.
- Minor flag latched on the same new_f: minor = (freq_id2≠31) and |freq_id1−freq_id2| ∈ {3, 15}.
- Chord offsets from base:
  - I: 0, 4, 7, 12 (minor: 0, 3, 7, 12).
  - IV: 5, 9, 12, 17 (minor: 5, 8, 12, 17).
  - V: 7, 11, 14, 19 (V is always major).
- Arithmetic is done in 6 bits. Any voice sum >30 has 12 subtracted, so a voice never equals 31.
- Transitions:
  - Any state, music=0 → IDLE. Highest priority.
  - Any state, new_f with freq_id1=31 → IDLE.
  - Any state, new_f with freq_id1≠31 and music=1 → latch base and minor, step=0, counter=0, → NOTE with chord I.
  - NOTE: counter increments on tick. On the tick where counter=2^NOTE_LENGTH−1 → SIL, counter=0.
  - SIL: counter increments on tick. On the terminal tick → step=step+1 (mod 4), counter=0, → NOTE with the new chord.
  - IDLE without an accepted new_f: stays IDLE. music rising does not restart; it waits for new_f.
- new_f and tick in the same cycle: new_f wins and the tick is dropped.
- new_f_notes pulses whenever any voice value changes, including the drop to rest when entering SIL or IDLE. It does not pulse if the voices are already 31.
- A single counter of width max(NOTE_LENGTH, SIL_LENGTH) serves both NOTE and SIL.

## Timing
- Every output is registered.
- Reset values: voices=31, new_f_notes=0, note=0, sil=0, step=0, state IDLE, counter=0, base=0, minor=0.
- Latency: one cycle from the triggering new_f or tick to the updated voices and new_f_notes.
- NOTE spans exactly 2^NOTE_LENGTH ticks; SIL spans exactly 2^SIL_LENGTH ticks.
- step wraps from 3 to 0 after the SIL that follows the second I.
- Reset asserted mid-operation returns every output to its reset value immediately, with no strobe.
- Back-to-back new_f: each accepted new_f restarts the progression and pulses new_f_notes if the voices change.

## Structure
- audio_pkg holds:
  - REST_ID=5'd31.
  - State enum {IDLE, NOTE, SIL}.
  - Step encodings.
  - Interval constants for the major and minor chords.
- Sub-module chord_voicer: combinational; inputs base, step and minor; outputs the four folded voice ids. It can be reused by a later progression controller.

## Test plan
All scenarios use NOTE_LENGTH=3, SIL_LENGTH=2, and tick every 4 cycles.
- Single id, major progression: reset, music=1, new_f with id1=2, id2=31.
  - Next cycle: voices 2/6/9/14, new_f_notes=1, note=1.
  - After 8 ticks: voices 31, sil=1.
  - After 4 more ticks: IV = 7/11/14/19. Then V = 9/13/16/21, then I.
  - step returns to 0 after 4 chords.
- Base reduction and fold:
  - id1=20 → base 8, I = 8/12/15/20.
  - id1=12 stepped to V → 19/23/26/19.
- Minor flavour: id1=5, id2=8 → I 5/8/12/17; IV 10/13/17/22; V 12/16/19/24.
- Priority:
  - new_f in the same cycle as a terminal NOTE tick → restart at I, state NOTE, counter 0.
  - music dropped mid-SIL → IDLE, no strobe.
  - music dropped mid-NOTE → voices 31, one strobe.
- Invalid id: new_f with id1=31 while in NOTE → IDLE, voices 31, new_f_notes=1 for one cycle.
- Async reset in NOTE (not aligned to the clock) → all outputs at reset values before the next clock edge. Sequencing resumes only after a fresh new_f.

Source files
------------

// File: rtl/chord_sequencer_pkg.sv
// Shared types and constants for the music-mode chord sequencer.
// Holds frequency id encodings, state and step enums, and chord interval tables.
package audio_pkg;

  typedef logic [4:0] freq_id_t;
  typedef logic [5:0] interval_t;
  typedef interval_t [3:0] chord_t;

  localparam freq_id_t REST_ID = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    SIL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_I     = 2'd0,
    STEP_IV    = 2'd1,
    STEP_V     = 2'd2,
    STEP_I_END = 2'd3
  } step_t;

  // Element [0] is the root voice.
  localparam chord_t MAJ_I  = {6'd12, 6'd7,  6'd4,  6'd0};
  localparam chord_t MIN_I  = {6'd12, 6'd7,  6'd3,  6'd0};
  localparam chord_t MAJ_IV = {6'd17, 6'd12, 6'd9,  6'd5};
  localparam chord_t MIN_IV = {6'd17, 6'd12, 6'd8,  6'd5};
  localparam chord_t DOM_V  = {6'd19, 6'd14, 6'd11, 6'd7};

  // Drop an octave when the sum would reach the rest id or beyond.
  function automatic freq_id_t fold_voice(freq_id_t base, interval_t offset);
    interval_t sum;
    sum = {1'b0, base} + offset;
    if (sum > 6'd30) begin
      sum = sum - 6'd12;
    end
    return sum[4:0];
  endfunction

endpackage

// File: rtl/chord_sequencer_if.sv
// Control and voice bus between the game logic and the chord sequencer.
interface chord_sequencer_if;

  logic               tick;
  logic               music;
  audio_pkg::freq_id_t freq_id1;
  audio_pkg::freq_id_t freq_id2;
  logic               new_f;
  audio_pkg::freq_id_t voice0;
  audio_pkg::freq_id_t voice1;
  audio_pkg::freq_id_t voice2;
  audio_pkg::freq_id_t voice3;
  logic               new_f_notes;
  logic               note;
  logic               sil;
  logic [1:0]         step;

  modport master (
    output tick, music, freq_id1, freq_id2, new_f,
    input  voice0, voice1, voice2, voice3, new_f_notes, note, sil, step
  );

  modport slave (
    input  tick, music, freq_id1, freq_id2, new_f,
    output voice0, voice1, voice2, voice3, new_f_notes, note, sil, step
  );

endinterface

// File: rtl/chord_sequencer_voicer.sv
// Combinational chord builder: base note, progression step and flavour in,
// four folded voice ids out.
module chord_voicer
  import audio_pkg::*;
(
  input  freq_id_t       base,
  input  step_t          step,
  input  logic           minor,
  output freq_id_t [3:0] voices
);

  chord_t offsets;

  // The dominant stays major regardless of the flavour.
  always_comb begin
    offsets = DOM_V;
    case (step)
      STEP_I, STEP_I_END: offsets = minor ? MIN_I : MAJ_I;
      STEP_IV:            offsets = minor ? MIN_IV : MAJ_IV;
      default:            offsets = DOM_V;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_voice
      assign voices[gi] = fold_voice(base, offsets[gi]);
    end
  endgenerate

endmodule

// File: rtl/chord_sequencer.sv
// I-IV-V-I chord sequencer with silences between chords, paced by an
// external tick; drives four voice ids and a change strobe.
module chord_sequencer
  import audio_pkg::*;
#(
  parameter int NOTE_LENGTH = 20,
  parameter int SIL_LENGTH  = 17
) (
  input  logic               clock,
  input  logic               reset,
  chord_sequencer_if.slave   bus
);

  localparam int CW = (NOTE_LENGTH > SIL_LENGTH) ? NOTE_LENGTH : SIL_LENGTH;
  localparam logic [CW-1:0] NOTE_LAST = CW'((64'd1 << NOTE_LENGTH) - 64'd1);
  localparam logic [CW-1:0] SIL_LAST  = CW'((64'd1 << SIL_LENGTH) - 64'd1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [1:0]     step_reg, step_next;
  freq_id_t       base_reg, base_next;
  logic           minor_reg, minor_next;
  freq_id_t [3:0] voice_reg, voice_next;
  logic           strobe_reg, strobe_next;
  logic           note_reg, note_next;
  logic           sil_reg, sil_next;

  freq_id_t       lower;
  freq_id_t       base_cand;
  logic [4:0]     id_diff;
  logic           minor_cand;
  freq_id_t [3:0] chord;

  // Base and flavour candidates from the current game ids.
  always_comb begin
    lower = bus.freq_id1;
    if (bus.freq_id2 != REST_ID && bus.freq_id2 < bus.freq_id1) begin
      lower = bus.freq_id2;
    end
    base_cand  = (lower < 5'd13) ? lower : lower - 5'd12;
    id_diff    = (bus.freq_id1 > bus.freq_id2) ? bus.freq_id1 - bus.freq_id2
                                               : bus.freq_id2 - bus.freq_id1;
    minor_cand = (bus.freq_id2 != REST_ID) && (id_diff == 5'd3 || id_diff == 5'd15);
  end

  // Next-state logic; a new_f in the same cycle swallows the tick.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    step_next  = step_reg;
    base_next  = base_reg;
    minor_next = minor_reg;
    if (!bus.music) begin
      state_next = IDLE;
      count_next = '0;
    end else if (bus.new_f && bus.freq_id1 == REST_ID) begin
      state_next = IDLE;
      count_next = '0;
    end else if (bus.new_f) begin
      state_next = NOTE;
      count_next = '0;
      step_next  = 2'd0;
      base_next  = base_cand;
      minor_next = minor_cand;
    end else if (bus.tick) begin
      case (state_reg)
        NOTE: begin
          if (count_reg == NOTE_LAST) begin
            state_next = SIL;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        SIL: begin
          if (count_reg == SIL_LAST) begin
            state_next = NOTE;
            count_next = '0;
            step_next  = step_reg + 2'd1;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  chord_voicer u_voicer (
    .base   (base_next),
    .step   (step_t'(step_next)),
    .minor  (minor_next),
    .voices (chord)
  );

  // Output values for the coming cycle; the strobe flags any voice change.
  always_comb begin
    voice_next  = {4{REST_ID}};
    if (state_next == NOTE) begin
      voice_next = chord;
    end
    strobe_next = (voice_next != voice_reg);
    note_next   = (state_next == NOTE);
    sil_next    = (state_next == SIL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      step_reg   <= 2'd0;
      base_reg   <= '0;
      minor_reg  <= 1'b0;
      voice_reg  <= {4{REST_ID}};
      strobe_reg <= 1'b0;
      note_reg   <= 1'b0;
      sil_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      step_reg   <= step_next;
      base_reg   <= base_next;
      minor_reg  <= minor_next;
      voice_reg  <= voice_next;
      strobe_reg <= strobe_next;
      note_reg   <= note_next;
      sil_reg    <= sil_next;
    end
  end

  assign bus.voice0      = voice_reg[0];
  assign bus.voice1      = voice_reg[1];
  assign bus.voice2      = voice_reg[2];
  assign bus.voice3      = voice_reg[3];
  assign bus.new_f_notes = strobe_reg;
  assign bus.note        = note_reg;
  assign bus.sil         = sil_reg;
  assign bus.step        = step_reg;

endmodule
